// File: rtl/bk_pipe_pkg.sv
// -----------------------------------------------------------------------------
// bk_pipe_pkg
// Shared sizing helpers for the pipelined Brent-Kung adder.
//   clog2            : ceiling log2
//   pad_width        : power-of-two prefix-tree width for a WIDTH-bit adder
//                      (one extra bit at index 0 carries the carry-in)
//   num_levels       : total Brent-Kung levels (up-sweep + down-sweep)
//   levels_in_stage  : number of prefix levels evaluated in a pipeline stage
//   level_lo         : first prefix level evaluated in a pipeline stage
// No ports (package).
// -----------------------------------------------------------------------------
package bk_pipe_pkg;

   localparam int unsigned MAX_WIDTH = 64;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = i + 1;
      end
      return r;
   endfunction

   function automatic int unsigned pad_width(input int unsigned width);
      return 32'd1 << clog2(width + 1);
   endfunction

   function automatic int unsigned num_levels(input int unsigned width);
      return 2 * clog2(width + 1) - 1;
   endfunction

   // Levels are split evenly; the remainder goes to the earliest stages.
   function automatic int unsigned levels_in_stage(input int unsigned stage,
                                                   input int unsigned latency,
                                                   input int unsigned width);
      int unsigned base;
      int unsigned rem;
      base = num_levels(width) / latency;
      rem  = num_levels(width) % latency;
      return base + ((stage < rem) ? 1 : 0);
   endfunction

   function automatic int unsigned level_lo(input int unsigned stage,
                                            input int unsigned latency,
                                            input int unsigned width);
      int unsigned base;
      int unsigned rem;
      base = num_levels(width) / latency;
      rem  = num_levels(width) % latency;
      return stage * base + ((stage < rem) ? stage : rem);
   endfunction

endpackage

// File: rtl/bk_prefix_levels.sv
// -----------------------------------------------------------------------------
// bk_prefix_levels
// Combinational slice of a Brent-Kung prefix tree: applies global levels
// [LO, HI) to an N-bit generate/propagate vector. Levels 0..LOG2N-1 are the
// up-sweep, the remaining LOG2N-1 levels the down-sweep. After all levels,
// bit j holds the group generate/propagate over bits [0..j].
// Ports:
//   i_g, i_p : N-bit generate / propagate in
//   o_g, o_p : N-bit generate / propagate out
// -----------------------------------------------------------------------------
module bk_prefix_levels #(
   parameter int unsigned N     = 16,
   parameter int unsigned LOG2N = 4,
   parameter int unsigned LO    = 0,
   parameter int unsigned HI    = 1
) (
   input  logic [N-1:0] i_g,
   input  logic [N-1:0] i_p,
   output logic [N-1:0] o_g,
   output logic [N-1:0] o_p
);

   localparam int unsigned NLEV = HI - LO;

   logic [NLEV:0][N-1:0] w_g;
   logic [NLEV:0][N-1:0] w_p;

   assign w_g[0] = i_g;
   assign w_p[0] = i_p;

   for (genvar k = 0; k < int'(NLEV); k++) begin : g_lvl
      localparam int  T  = int'(LO) + k;
      localparam bit  UP = (T < int'(LOG2N));
      localparam int  L  = UP ? T : (2 * int'(LOG2N) - 2 - T);
      localparam int  D  = 1 << L;
      for (genvar j = 0; j < int'(N); j++) begin : g_bit
         // Up-sweep combines at the top of each 2D block; down-sweep fills
         // the midpoints that the up-sweep skipped.
         localparam bit COMB = UP ? (((j + 1) % (2 * D)) == 0)
                                  : ((((j + 1) % (2 * D)) == D) && (j >= 3 * D - 1));
         if (COMB) begin : g_op
            assign w_g[k+1][j] = w_g[k][j] | (w_p[k][j] & w_g[k][j-D]);
            assign w_p[k+1][j] = w_p[k][j] & w_p[k][j-D];
         end else begin : g_pass
            assign w_g[k+1][j] = w_g[k][j];
            assign w_p[k+1][j] = w_p[k][j];
         end
      end
   end

   assign o_g = w_g[NLEV];
   assign o_p = w_p[NLEV];

endmodule

// File: rtl/bk_pipe_adder.sv
// -----------------------------------------------------------------------------
// bk_pipe_adder
// Pipelined Brent-Kung adder/subtractor with valid/ready on both sides.
// Prefix levels are spread over LATENCY register stages; stalls collapse
// bubbles. The carry-in is folded into the tree as bit index 0, so tree bit
// i+1 corresponds to operand bit i and tree bit i ends as the carry into
// operand bit i.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake
//   in_a, in_b          : operands
//   in_cin              : carry-in (ignored when in_sub=1)
//   in_sub              : 1 = A - B
//   out_valid/out_ready : output handshake
//   out_sum             : result, modulo 2^WIDTH
//   out_cout            : carry out of MSB (subtract: 1 = no borrow)
//   out_ovf             : signed overflow
// -----------------------------------------------------------------------------
module bk_pipe_adder
   import bk_pipe_pkg::*;
#(
   parameter int unsigned WIDTH   = 12,
   parameter int unsigned LATENCY = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf
);

   localparam int unsigned N     = pad_width(WIDTH);
   localparam int unsigned LOG2N = clog2(WIDTH + 1);

   typedef struct packed {
      logic             vld;
      logic [N-1:0]     g;
      logic [N-1:0]     p;
      logic [WIDTH-1:0] p0;
   } pg_rec_t;

   pg_rec_t [LATENCY-1:0]          r_st;
   pg_rec_t [LATENCY-1:0]          w_src;
   logic    [LATENCY-1:0][N-1:0]   w_go;
   logic    [LATENCY-1:0][N-1:0]   w_po;
   logic    [LATENCY-1:0]          w_en;

   logic [WIDTH-1:0] w_bx;
   logic [WIDTH-1:0] w_p0;
   logic             w_c0;
   logic [N-1:0]     w_g_in;
   logic [N-1:0]     w_p_in;
   logic             w_unused_bits;

   // Operand conditioning: subtract is A + ~B + 1.
   assign w_bx = in_sub ? ~in_b : in_b;
   assign w_c0 = in_sub | in_cin;
   assign w_p0 = in_a ^ w_bx;

   // Padding bits above WIDTH stay zero so they never disturb the carries.
   always_comb begin
      w_g_in          = '0;
      w_p_in          = '0;
      w_g_in[0]       = w_c0;
      w_g_in[WIDTH:1] = in_a & w_bx;
      w_p_in[WIDTH:1] = w_p0;
   end

   for (genvar k = 0; k < int'(LATENCY); k++) begin : g_stage
      localparam int unsigned LO = level_lo(k, LATENCY, WIDTH);
      localparam int unsigned HI = LO + levels_in_stage(k, LATENCY, WIDTH);

      if (k == 0) begin : g_src_in
         assign w_src[k].vld = in_valid;
         assign w_src[k].g   = w_g_in;
         assign w_src[k].p   = w_p_in;
         assign w_src[k].p0  = w_p0;
      end else begin : g_src_prev
         assign w_src[k] = r_st[k-1];
      end

      bk_prefix_levels #(
         .N     (N),
         .LOG2N (LOG2N),
         .LO    (LO),
         .HI    (HI)
      ) u_levels (
         .i_g (w_src[k].g),
         .i_p (w_src[k].p),
         .o_g (w_go[k]),
         .o_p (w_po[k])
      );
   end

   // A stage may load when it is empty or its content is moving on.
   always_comb begin
      w_en              = '0;
      w_en[LATENCY-1]   = ~r_st[LATENCY-1].vld | out_ready;
      for (int unsigned i = 1; i < LATENCY; i++) begin
         w_en[LATENCY-1-i] = ~r_st[LATENCY-1-i].vld | w_en[LATENCY-i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_st <= '0;
      end else begin
         for (int unsigned k = 0; k < LATENCY; k++) begin
            if (w_en[k]) begin
               r_st[k].vld <= w_src[k].vld;
               r_st[k].g   <= w_go[k];
               r_st[k].p   <= w_po[k];
               r_st[k].p0  <= w_src[k].p0;
            end
         end
      end
   end

   assign in_ready  = ~rst & w_en[0];
   assign out_valid = r_st[LATENCY-1].vld;
   assign out_sum   = r_st[LATENCY-1].p0 ^ r_st[LATENCY-1].g[WIDTH-1:0];
   assign out_cout  = r_st[LATENCY-1].g[WIDTH];
   assign out_ovf   = r_st[LATENCY-1].g[WIDTH] ^ r_st[LATENCY-1].g[WIDTH-1];

   // Final-stage group propagates and padding generates are not needed.
   assign w_unused_bits = ^{r_st[LATENCY-1].p, r_st[LATENCY-1].g};

endmodule
